// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port of the multicycle MIPS between the CPU
//   (instruction fetch, lw/sw) and a DMA/loader port. It arbitrates in IDLE,
//   runs a fixed-latency ACCESS phase on the memory and returns a one-cycle
//   ack to the owner in DONE. The CPU normally wins ties. A starvation counter
//   hands the port to a waiting DMA after MAX_WAIT consecutive CPU grants.
//
// Parameters
//   ADDR_W    address width
//   DATA_W    data width
//   MEM_LAT   memory access cycles per transfer (>= 1)
//   MAX_WAIT  consecutive CPU grants allowed while dma_req is pending
//             (0: DMA always wins a tie)
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request; req held until cpu_ack
//   cpu_rdata, cpu_ack            CPU read data (held until next CPU read ack), ack pulse
//   dma_req/we/addr/wdata         DMA request; req held until dma_ack
//   dma_rdata, dma_ack            DMA read data (same validity rule), ack pulse
//   mem_addr, mem_wdata           memory address / write data, held outside ACCESS
//   mem_read, mem_write           read enable (all ACCESS cycles), write strobe (last one)
//   mem_rdata                     memory read data, valid in the last ACCESS cycle
//   busy                          state is ACCESS or DONE
//   gnt_dma                       owner of the current or last transfer (1 = DMA)

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              gnt_dma
);

    // Counter widths: lat_cnt counts MEM_LAT-1 down to 0, starve_cnt saturates at MAX_WAIT.
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
    localparam logic [SW-1:0]    WAIT_LIM = SW'(MAX_WAIT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [SW-1:0]     starve_cnt;

    // Transfer descriptor captured at the grant.
    logic              owner_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    // Per-port read data captured at the end of ACCESS.
    logic [DATA_W-1:0] cpu_rdata_p1;
    logic [DATA_W-1:0] dma_rdata_p1;

    logic              any_req;
    logic              dma_wins;

    // Starvation counter update at a grant: a CPU grant that leaves the DMA
    // waiting counts up (saturating); anything else restarts the count.
    function automatic logic [SW-1:0] starve_next(
        input logic [SW-1:0] cnt,
        input logic          dma_granted,
        input logic          dma_pending
    );
        if (dma_granted || !dma_pending) begin
            return '0;
        end
        if (cnt >= WAIT_LIM) begin
            return WAIT_LIM;
        end
        return cnt + 1'b1;
    endfunction

    assign any_req  = cpu_req | dma_req;
    // With MAX_WAIT = 0 the counter is always at its limit, so DMA wins every tie.
    assign dma_wins = dma_req & (~cpu_req | (starve_cnt == WAIT_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            starve_cnt   <= '0;
            owner_p0     <= 1'b0;
            we_p0        <= 1'b0;
            addr_p0      <= '0;
            wdata_p0     <= '0;
            cpu_rdata_p1 <= '0;
            dma_rdata_p1 <= '0;
        end else begin
            case (state)
                // Grant stage: sample requests, latch the winner's descriptor.
                S_IDLE: begin
                    if (any_req) begin
                        owner_p0   <= dma_wins;
                        we_p0      <= dma_wins ? dma_we    : cpu_we;
                        addr_p0    <= dma_wins ? dma_addr  : cpu_addr;
                        wdata_p0   <= dma_wins ? dma_wdata : cpu_wdata;
                        lat_cnt    <= LAT_INIT;
                        starve_cnt <= starve_next(starve_cnt, dma_wins, dma_req);
                        state      <= S_ACCESS;
                    end
                end

                // Access stage: count down the memory latency, capture read data
                // into the owner's register on the final cycle.
                S_ACCESS: begin
                    if (lat_cnt == '0) begin
                        if (!we_p0) begin
                            if (owner_p0) begin
                                dma_rdata_p1 <= mem_rdata;
                            end else begin
                                cpu_rdata_p1 <= mem_rdata;
                            end
                        end
                        state <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                // Completion stage: ack is decoded from the state, one cycle only.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Address and write data come straight from the latched descriptor, so
    // they keep the last transfer's values outside ACCESS instead of dropping to 0.
    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;
    assign mem_read  = (state == S_ACCESS) & ~we_p0;
    // A single write strobe on the last access cycle.
    assign mem_write = (state == S_ACCESS) & we_p0 & (lat_cnt == '0);

    assign cpu_ack   = (state == S_DONE) & ~owner_p0;
    assign dma_ack   = (state == S_DONE) &  owner_p0;
    assign cpu_rdata = cpu_rdata_p1;
    assign dma_rdata = dma_rdata_p1;

    assign busy      = (state != S_IDLE);
    assign gnt_dma   = owner_p0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (MAX_WAIT = 4)
    logic          cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          cpu_ack, dma_ack, mem_read, mem_write, busy, gnt_dma;

    // Second instance (MAX_WAIT = 0)
    logic          c0_req = 0, d0_req = 0;
    logic [DW-1:0] c0_rdata, d0_rdata, m0_wdata, m0_rdata;
    logic [AW-1:0] m0_addr;
    logic          c0_ack, d0_ack, m0_read, m0_write, busy0, gnt0;
    assign m0_rdata = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .gnt_dma(gnt_dma)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(c0_req), .cpu_we(1'b0), .cpu_addr(32'h100), .cpu_wdata(32'h0),
        .cpu_rdata(c0_rdata), .cpu_ack(c0_ack),
        .dma_req(d0_req), .dma_we(1'b0), .dma_addr(32'h200), .dma_wdata(32'h0),
        .dma_rdata(d0_rdata), .dma_ack(d0_ack),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_read(m0_read),
        .mem_write(m0_write), .mem_rdata(m0_rdata), .busy(busy0), .gnt_dma(gnt0)
    );

    // Memory behind the main instance: combinational read, write on the strobe.
    logic [DW-1:0] env_mem [0:255];
    assign mem_rdata = mem_read ? env_mem[mem_addr[7:0]] : '0;
    always @(negedge clk) if (mem_write) env_mem[mem_addr[7:0]] = mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a transfer occupies LAT+1 cycles after its grant
    // (LAT access cycles then one ack cycle); m_rem counts the cycles left.
    logic [DW-1:0] model_mem [0:255];
    int            m_rem = 0;
    int            m_wait = 0;    // CPU grants issued while the DMA kept waiting
    bit            m_own = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd_c = '0, m_rd_d = '0;

    always @(posedge clk) begin
        // The write strobe of the last access cycle reaches memory even if a reset follows.
        if (m_rem == 2 && m_we) model_mem[m_addr[7:0]] = m_wdata;
        if (rst) begin
            m_rem = 0; m_wait = 0; m_own = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_rd_c = '0; m_rd_d = '0;
        end else if (m_rem == 0) begin
            if (cpu_req || dma_req) begin
                m_own = dma_req && (!cpu_req || m_wait == MW);
                if (!m_own && dma_req) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
                else m_wait = 0;
                m_we    = m_own ? dma_we : cpu_we;
                m_addr  = m_own ? dma_addr : cpu_addr;
                m_wdata = m_own ? dma_wdata : cpu_wdata;
                m_rem   = LAT + 1;
            end
        end else begin
            if (m_rem == 2 && !m_we) begin
                if (m_own) m_rd_d = model_mem[m_addr[7:0]];
                else       m_rd_c = model_mem[m_addr[7:0]];
            end
            m_rem = m_rem - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk1("cpu_ack",   cpu_ack,   m_rem == 1 && !m_own);
        chk1("dma_ack",   dma_ack,   m_rem == 1 && m_own);
        chk1("busy",      busy,      m_rem != 0);
        chk1("gnt_dma",   gnt_dma,   m_own);
        chk1("mem_read",  mem_read,  m_rem >= 2 && !m_we);
        chk1("mem_write", mem_write, m_rem == 2 && m_we);
        chk("mem_addr",   mem_addr,  m_addr);
        chk("mem_wdata",  mem_wdata, m_wdata);
        chk("cpu_rdata",  cpu_rdata, m_rd_c);
        chk("dma_rdata",  dma_rdata, m_rd_d);
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    task automatic rand_cpu();
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom() & 32'hFFFF_000F; cpu_wdata = $urandom();
    endtask

    task automatic rand_dma();
        dma_req = 1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = $urandom() & 32'hFFFF_000F; dma_wdata = $urandom();
    endtask

    // Single transfer from an idle arbiter; reports ack cycle and memory activity.
    task automatic do_xfer(input bit is_dma, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int ack_at, output int rd_n,
                           output int wr_n, output int other_n,
                           output logic [31:0] wa, output logic [31:0] wd);
        ack_at = -1; rd_n = 0; wr_n = 0; other_n = 0; wa = '0; wd = '0;
        if (is_dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
        else        begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        for (int c = 1; c <= 20; c++) begin
            step();
            if (mem_read) rd_n++;
            if (mem_write) begin wr_n++; wa = mem_addr; wd = mem_wdata; end
            if (is_dma ? cpu_ack : dma_ack) other_n++;
            if (is_dma ? dma_ack : cpu_ack) begin
                ack_at = c;
                if (is_dma) dma_req = 0; else cpu_req = 0;
                break;
            end
        end
        step();
    endtask

    int seq [16];

    // Collect n acks with requests kept high; each acked port re-requests.
    task automatic collect_acks(input int n);
        int got = 0;
        for (int i = 0; i < 16; i++) seq[i] = -1;
        for (int c = 0; c < 200 && got < n; c++) begin
            step();
            if (cpu_ack) begin seq[got] = 0; got++; rand_cpu(); end
            if (dma_ack) begin seq[got] = 1; got++; rand_dma(); end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            step();
            if (cpu_ack) cpu_req = 0;
            if (dma_ack) dma_req = 0;
            if (!cpu_req && !dma_req && !busy) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the end of the run");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_at, rd_n, wr_n, other_n, n1, n2, first_ack, second_ack, got0;
        logic [31:0] wa, wd;
        bit first_seen, found;
        int exp3 [10];
        exp3 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
            model_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        env_mem[8'h10] = 32'hDEAD_BEEF; model_mem[8'h10] = 32'hDEAD_BEEF;
        env_mem[8'h20] = 32'h1111_2222; model_mem[8'h20] = 32'h1111_2222;
        env_mem[8'h24] = 32'h3333_4444; model_mem[8'h24] = 32'h3333_4444;

        // Reset state
        step();
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_gnt", gnt_dma, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        rst = 0;
        step();

        // CPU read of 0x10
        do_xfer(0, 0, 32'h10, 32'h0, ack_at, rd_n, wr_n, other_n, wa, wd);
        chk("t1_ack_cycle", ack_at, LAT + 1);
        chk("t1_read_cycles", rd_n, LAT);
        chk("t1_write_cycles", wr_n, 0);
        chk("t1_dma_ack", other_n, 0);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t1_dma_rdata", dma_rdata, 32'h0);

        // DMA write to 0x40
        do_xfer(1, 1, 32'h40, 32'hA5A5_A5A5, ack_at, rd_n, wr_n, other_n, wa, wd);
        chk("t2_ack_cycle", ack_at, LAT + 1);
        chk("t2_write_cycles", wr_n, 1);
        chk("t2_write_addr", wa, 32'h40);
        chk("t2_write_data", wd, 32'hA5A5_A5A5);
        chk("t2_read_cycles", rd_n, 0);
        chk("t2_cpu_ack", other_n, 0);
        chk("t2_mem", env_mem[8'h40], 32'hA5A5_A5A5);

        // CPU request held across its ack with a new address
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        n1 = -100; n2 = 0; first_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (cpu_ack && !first_seen) begin
                first_seen = 1; n1 = c;
                chk("t6_first_rdata", cpu_rdata, 32'h1111_2222);
                cpu_addr = 32'h24;
            end else if (cpu_ack) begin
                n2 = c; cpu_req = 0;
                chk("t6_second_rdata", cpu_rdata, 32'h3333_4444);
                break;
            end else if (first_seen) begin
                chk("t6_hold_rdata", cpu_rdata, 32'h1111_2222);
            end
        end
        chk("t6_ack_spacing", n2 - n1, LAT + 2);
        step();

        // Both requests held: C,C,C,C,D repeating
        rand_cpu(); rand_dma();
        collect_acks(10);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_grant_%0d", i), seq[i], exp3[i]);

        // Two more CPU grants build up the DMA wait, then a CPU write is reset mid-access
        collect_acks(2);
        chk("t5_pre0", seq[0], 0);
        chk("t5_pre1", seq[1], 0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h0000_0077;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (busy && mem_write && !gnt_dma) begin found = 1; break; end
        end
        chk1("t5_strobe_seen", found, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk1("t5_no_ack", cpu_ack, 1'b0);
        chk1("t5_mem_write", mem_write, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        // A cleared starvation count shows as four CPU grants before the DMA.
        collect_acks(5);
        for (int i = 0; i < 5; i++) chk($sformatf("t5_grant_%0d", i), seq[i], exp3[i]);
        drain();

        // MAX_WAIT = 0: simultaneous requests go DMA first
        c0_req = 1; d0_req = 1;
        first_ack = -1; second_ack = -1; got0 = 0;
        for (int c = 0; c < 30 && got0 < 2; c++) begin
            step();
            chk1("t4_ack_excl", c0_ack & d0_ack, 1'b0);
            if (c0_ack || d0_ack) begin
                if (got0 == 0) first_ack = int'(d0_ack); else second_ack = int'(d0_ack);
                got0++;
                if (c0_ack) c0_req = 0;
                if (d0_ack) d0_req = 0;
            end
        end
        chk("t4_first_is_dma", first_ack, 1);
        chk("t4_second_is_cpu", second_ack, 0);
        c0_req = 0; d0_req = 0;

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            step();
            if (rst) rst = 0;
            else if ($urandom_range(0, 99) == 0) rst = 1;
            if (cpu_ack) begin
                if ($urandom_range(0, 1) == 1) rand_cpu(); else cpu_req = 0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) rand_cpu();
            if (dma_ack) begin
                if ($urandom_range(0, 1) == 1) rand_dma(); else dma_req = 0;
            end else if (!dma_req && $urandom_range(0, 2) == 0) rand_dma();
        end
        rst = 0;
        drain();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
